// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths, zero word,
// controller state encoding and the packed read-port slicing helper.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    // LSB position of port 'port' inside a packed bus of 'width'-bit fields
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_sb.sv
// Pending-write scoreboard: one bit per register, bit 0 hardwired to zero.
// Set beats clear for the same register in the same cycle; clr_all_i empties it.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     clr_all_i,
    input  logic                     set_en_i,
    input  logic [ADDR_W-1:0]        set_addr_i,
    input  logic                     clr0_en_i,
    input  logic [ADDR_W-1:0]        clr0_addr_i,
    input  logic                     clr1_en_i,
    input  logic [ADDR_W-1:0]        clr1_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD-1:0]        pend_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr0_en_i) pend_d[clr0_addr_i] = 1'b0;
        if (clr1_en_i) pend_d[clr1_addr_i] = 1'b0;
        if (set_en_i)  pend_d[set_addr_i]  = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr_all_i) pend_q <= '0;
        else           pend_q <= pend_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
        localparam int unsigned AL = port_lsb(k, ADDR_W);
        assign pend_o[k] = pend_q[raddr_i[AL +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with dual write ports, pending-write scoreboard and a
// sequenced post-reset clear. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output logic                     ready,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic [NUM_RD-1:0]        rpend
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic run;
    logic clear_all;
    logic wr0_act, wr1_act;
    logic [NUM_RD-1:0] sb_pend;

    assign run   = (state_q == ST_RUN);
    assign ready = run;

    // Writes to r0 never count as active: they neither store nor clear the scoreboard
    assign wr0_act = run && we0 && (waddr0 != '0);
    assign wr1_act = run && we1 && (waddr1 != '0);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clear_all = 1'b0;
        if (rst || (run && clr)) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
            clear_all = 1'b1;
        end else if (!run) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Storage: clear sequencer in CLEAR, functional writes in RUN (port 1 wins on collision)
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                regs_q[clr_idx_q] <= '0;
            end else if (!clr) begin
                if (wr0_act) regs_q[waddr0] <= wdata0;
                if (wr1_act) regs_q[waddr1] <= wdata1;
            end
        end
    end

    regfile_sb #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk         (clk),
        .clr_all_i   (clear_all),
        .set_en_i    (run && pend_set),
        .set_addr_i  (pend_addr),
        .clr0_en_i   (wr0_act),
        .clr0_addr_i (waddr0),
        .clr1_en_i   (wr1_act),
        .clr1_addr_i (waddr1),
        .raddr_i     (raddr),
        .pend_o      (sb_pend)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int unsigned AL = port_lsb(k, ADDR_W);
        localparam int unsigned DL = port_lsb(k, DATA_W);

        logic [ADDR_W-1:0] ra;
        logic              live;
        logic [DATA_W-1:0] rd_val;
        logic              pd_val;

        assign ra   = raddr[AL +: ADDR_W];
        assign live = run && re[k] && (ra != '0);

`ifdef REGFILE_BYPASS_EN
        logic hit0, hit1;
        assign hit0 = wr0_act && (waddr0 == ra);
        assign hit1 = wr1_act && (waddr1 == ra);

        always_comb begin
            rd_val = '0;
            pd_val = 1'b0;
            if (live) begin
                if (hit1)      rd_val = wdata1;
                else if (hit0) rd_val = wdata0;
                else           rd_val = regs_q[ra];
                pd_val = sb_pend[k] && !(hit0 || hit1);
            end
        end
`else
        always_comb begin
            rd_val = '0;
            pd_val = 1'b0;
            if (live) begin
                rd_val = regs_q[ra];
                pd_val = sb_pend[k];
            end
        end
`endif

        assign rdata[DL +: DATA_W] = rd_val;
        assign rpend[k]            = pd_val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (default 32x32, two read ports);
// expectations follow REGFILE_BYPASS_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, clr, ready;
    logic             we0, we1;
    logic [AW-1:0]    waddr0, waddr1;
    logic [DW-1:0]    wdata0, wdata1;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic             pend_set;
    logic [AW-1:0]    pend_addr;
    logic [NR-1:0]    rpend;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          sig;
        int          port;
        logic [31:0] exp;
    } chk_t;

    chk_t  chkq[$];
    string tagq[$];

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .ready     (ready),
        .we0       (we0),
        .we1       (we1),
        .waddr0    (waddr0),
        .waddr1    (waddr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .rpend     (rpend)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        re = '0; raddr = '0; pend_set = 1'b0; pend_addr = '0; clr = 1'b0;
    endtask

    task automatic rd(input int port, input logic [AW-1:0] a);
        re[port] = 1'b1;
        raddr[port*AW +: AW] = a;
    endtask

    // sig: 0 = rdata, 1 = rpend, 2 = ready
    task automatic expect_v(input string tag, input int sig, input int port, input logic [31:0] v);
        chk_t c;
        c.sig = sig; c.port = port; c.exp = v;
        chkq.push_back(c);
        tagq.push_back(tag);
    endtask

    // Compare everything queued for this cycle, then advance one clock edge
    task automatic cyc();
        chk_t        c;
        string       t;
        logic [31:0] obs;
        @(negedge clk);
        while (chkq.size() > 0) begin
            c = chkq.pop_front();
            t = tagq.pop_front();
            case (c.sig)
                0:       obs = rdata[c.port*DW +: DW];
                1:       obs = {31'b0, rpend[c.port]};
                default: obs = {31'b0, ready};
            endcase
            vectors++;
            assert (obs === c.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", t, obs, c.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle after the edge that entered CLEAR; ready must rise after 32 more edges
    task automatic wait_clear(input int clr_at, input int junk_at);
        idle();
        rd(0, 5'd1);
        rd(1, 5'd12);
        expect_v("ready_clr0", 2, 0, 32'd0);
        expect_v("rdata_clr", 0, 0, ZERO_WORD);
        expect_v("rpend_clr", 1, 1, 32'd0);
        cyc();
        for (int c = 1; c <= 32; c++) begin
            clr       = (c == clr_at);
            we0       = (c == junk_at);
            waddr0    = 5'd1;
            wdata0    = 32'hBAD0BAD0;
            pend_set  = (c == junk_at);
            pend_addr = 5'd12;
            expect_v("ready_seq", 2, 0, {31'b0, c == 32});
            expect_v("rdata_clr", 0, 0, ZERO_WORD);
            expect_v("rpend_clr", 1, 1, 32'd0);
            cyc();
        end
        idle();
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < 32; a += 2) begin
            idle();
            rd(0, AW'(a));
            rd(1, AW'(a + 1));
            expect_v("zero_rd0", 0, 0, ZERO_WORD);
            expect_v("zero_rd1", 0, 1, ZERO_WORD);
            expect_v("zero_rp0", 1, 0, 32'd0);
            expect_v("zero_rp1", 1, 1, 32'd0);
            cyc();
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear(0, 0);
        read_all_zero();

        // single write on port 0, then read back
        idle(); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; rd(0, 5'd5);
        expect_v("r5_same", 0, 0, BYP ? 32'hDEADBEEF : 32'h0);
        cyc();
        idle(); rd(0, 5'd5);
        expect_v("r5_next", 0, 0, 32'hDEADBEEF);
        cyc();

        // r0 is never written
        idle(); we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1234; rd(1, 5'd0);
        expect_v("r0_same", 0, 1, 32'h0);
        cyc();
        idle(); rd(0, 5'd0);
        expect_v("r0_next", 0, 0, 32'h0);
        cyc();

        // same-address collision: port 1 wins
        idle();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        rd(0, 5'd7);
        expect_v("r7_same", 0, 0, BYP ? 32'h22222222 : 32'h0);
        cyc();
        idle(); rd(0, 5'd7); rd(1, 5'd7);
        expect_v("r7_next0", 0, 0, 32'h22222222);
        expect_v("r7_next1", 0, 1, 32'h22222222);
        cyc();

        // independent writes on both ports
        idle();
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h0000000A;
        we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h0000000B;
        rd(0, 5'd10); rd(1, 5'd11);
        expect_v("r10_same", 0, 0, BYP ? 32'h0000000A : 32'h0);
        expect_v("r11_same", 0, 1, BYP ? 32'h0000000B : 32'h0);
        cyc();
        idle(); rd(0, 5'd10); rd(1, 5'd11);
        expect_v("r10_next", 0, 0, 32'h0000000A);
        expect_v("r11_next", 0, 1, 32'h0000000B);
        cyc();

        // scoreboard on r9
        idle(); pend_set = 1'b1; pend_addr = 5'd9; rd(1, 5'd9);
        expect_v("r9_pend_same", 1, 1, 32'd0);
        cyc();
        idle(); rd(1, 5'd9); raddr[AW-1:0] = 5'd9;
        expect_v("r9_pend_next", 1, 1, 32'd1);
        expect_v("r9_pend_re0", 1, 0, 32'd0);
        expect_v("r9_data_re0", 0, 0, 32'h0);
        cyc();
        idle(); we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99; pend_set = 1'b1; pend_addr = 5'd9; rd(1, 5'd9);
        expect_v("r9_setclr_pend", 1, 1, BYP ? 32'd0 : 32'd1);
        expect_v("r9_setclr_data", 0, 1, BYP ? 32'h99 : 32'h0);
        cyc();
        idle(); rd(1, 5'd9);
        expect_v("r9_setwins", 1, 1, 32'd1);
        expect_v("r9_data99", 0, 1, 32'h99);
        cyc();
        idle(); we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h77; rd(1, 5'd9);
        expect_v("r9_clr_pend", 1, 1, BYP ? 32'd0 : 32'd1);
        expect_v("r9_clr_data", 0, 1, BYP ? 32'h77 : 32'h99);
        cyc();
        idle(); rd(1, 5'd9);
        expect_v("r9_cleared", 1, 1, 32'd0);
        expect_v("r9_data77", 0, 1, 32'h77);
        cyc();

        // forwarding behaviour on a pending register
        idle(); pend_set = 1'b1; pend_addr = 5'd3;
        cyc();
        idle(); we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5; rd(0, 5'd3);
        expect_v("r3_fwd_data", 0, 0, BYP ? 32'hA5A5A5A5 : 32'h0);
        expect_v("r3_fwd_pend", 1, 0, BYP ? 32'd0 : 32'd1);
        cyc();
        idle(); rd(0, 5'd3);
        expect_v("r3_data", 0, 0, 32'hA5A5A5A5);
        expect_v("r3_pend", 1, 0, 32'd0);
        cyc();

        // leave r12 pending so the reset must clear it
        idle(); pend_set = 1'b1; pend_addr = 5'd12;
        cyc();
        idle(); rd(1, 5'd12);
        expect_v("r12_pend", 1, 1, 32'd1);
        cyc();

        // reset from RUN, then again in mid-clear at index 10
        idle(); rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_v("ready_mid", 2, 0, 32'd0);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_clear(0, 0);
        read_all_zero();

        // soft clear from RUN; clr during CLEAR and junk writes must be ignored
        idle(); we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'h55; pend_set = 1'b1; pend_addr = 5'd12;
        cyc();
        idle(); rd(0, 5'd20); rd(1, 5'd12);
        expect_v("r20_data", 0, 0, 32'h55);
        expect_v("r12_pend2", 1, 1, 32'd1);
        cyc();
        idle(); clr = 1'b1;
        cyc();
        wait_clear(5, 20);
        read_all_zero();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
